// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
// The request side is held stable from the request until dmem_ack.
interface mem_stage_if #(
    parameter int WORD_SIZE = 32
);
    logic                 dmem_req;
    logic                 dmem_we;
    logic [WORD_SIZE-1:0] dmem_addr;
    logic [3:0]           dmem_be;
    logic [WORD_SIZE-1:0] dmem_wdata;
    logic [WORD_SIZE-1:0] dmem_rdata;
    logic                 dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: word-addressed loads/stores over a req/ack bus, load
// alignment and extension, store lane generation, and the MEM/WB registers.
module mem_stage #(
    parameter int WORD_SIZE      = 32,
    parameter int NUM_REGS       = 32,
    parameter int REG_SEL        = $clog2(NUM_REGS),
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] in_result,
    input  logic [WORD_SIZE-1:0] in_write_data,
    input  logic [REG_SEL-1:0]   in_rd,
    input  logic                 in_reg_write,
    input  logic                 in_mem_read,
    input  logic                 in_mem_write,
    input  logic [1:0]           in_data_size,
    input  logic                 in_data_sign,
    mem_stage_if.master          dmem,
    output logic                 wb_valid,
    output logic                 wb_reg_write,
    output logic [REG_SEL-1:0]   wb_rd,
    output logic [WORD_SIZE-1:0] wb_data,
    output logic [WORD_SIZE-1:0] mem_forward,
    output logic                 misalign,
    output logic                 bus_error
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [1:0]           lane_q;
    logic [1:0]           size_q;
    logic                 sign_q;
    logic                 reg_write_q;
    logic                 is_store_q;
    logic [REG_SEL-1:0]   rd_q;
    logic                 req_q;
    logic                 we_q;
    logic [WORD_SIZE-1:0] addr_q;
    logic [3:0]           be_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic                 wb_valid_q;
    logic                 wb_reg_write_q;
    logic [REG_SEL-1:0]   wb_rd_q;
    logic [WORD_SIZE-1:0] wb_data_q;
    logic                 misalign_q;
    logic                 bus_error_q;

    logic                 misaligned;
    logic [3:0]           be_d;
    logic [WORD_SIZE-1:0] wdata_d;
    logic [WORD_SIZE-1:0] shifted;
    logic [WORD_SIZE-1:0] load_data_d;

    always_comb begin
        misaligned = 1'b0;
        case (in_data_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = in_result[0];
            default: misaligned = |in_result[1:0];
        endcase
    end

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = in_write_data;
        if (in_mem_write) begin
            case (in_data_size)
                2'b00: begin
                    be_d    = 4'b0001 << in_result[1:0];
                    wdata_d = {4{in_write_data[7:0]}};
                end
                2'b01: begin
                    be_d    = 4'b0011 << in_result[1:0];
                    wdata_d = {2{in_write_data[15:0]}};
                end
                default: begin
                    be_d    = 4'b1111;
                    wdata_d = in_write_data;
                end
            endcase
        end
    end

    // Load data arrives word-aligned; move the addressed lane down to bit 0.
    always_comb begin
        shifted     = dmem.dmem_rdata >> {lane_q, 3'b000};
        load_data_d = dmem.dmem_rdata;
        case (size_q)
            2'b00:   load_data_d = {{(WORD_SIZE-8){sign_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_data_d = {{(WORD_SIZE-16){sign_q & shifted[15]}}, shifted[15:0]};
            default: load_data_d = dmem.dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            lane_q         <= '0;
            size_q         <= '0;
            sign_q         <= 1'b0;
            reg_write_q    <= 1'b0;
            is_store_q     <= 1'b0;
            rd_q           <= '0;
            req_q          <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            be_q           <= '0;
            wdata_q        <= '0;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
            misalign_q     <= 1'b0;
            bus_error_q    <= 1'b0;
        end else begin
            wb_valid_q  <= 1'b0;
            misalign_q  <= 1'b0;
            bus_error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (!(in_mem_read || in_mem_write)) begin
                            wb_valid_q     <= 1'b1;
                            wb_data_q      <= in_result;
                            wb_rd_q        <= in_rd;
                            wb_reg_write_q <= in_reg_write;
                        end else if (misaligned) begin
                            misalign_q     <= 1'b1;
                            wb_valid_q     <= 1'b1;
                            wb_reg_write_q <= 1'b0;
                        end else begin
                            state_q     <= BUSY;
                            cnt_q       <= '0;
                            lane_q      <= in_result[1:0];
                            size_q      <= in_data_size;
                            sign_q      <= in_data_sign;
                            reg_write_q <= in_reg_write;
                            is_store_q  <= in_mem_write;
                            rd_q        <= in_rd;
                            req_q       <= 1'b1;
                            we_q        <= in_mem_write;
                            addr_q      <= {in_result[WORD_SIZE-1:2], 2'b00};
                            be_q        <= be_d;
                            wdata_q     <= wdata_d;
                        end
                    end
                end
                BUSY: begin
                    // An ack on the final counted cycle still completes normally.
                    if (dmem.dmem_ack) begin
                        state_q    <= IDLE;
                        req_q      <= 1'b0;
                        we_q       <= 1'b0;
                        wb_valid_q <= 1'b1;
                        wb_rd_q    <= rd_q;
                        if (is_store_q) begin
                            wb_reg_write_q <= 1'b0;
                        end else begin
                            wb_reg_write_q <= reg_write_q;
                            wb_data_q      <= load_data_d;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        state_q        <= IDLE;
                        req_q          <= 1'b0;
                        we_q           <= 1'b0;
                        bus_error_q    <= 1'b1;
                        wb_valid_q     <= 1'b1;
                        wb_reg_write_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready        = (state_q == IDLE);
    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_wdata = wdata_q;
    assign wb_valid        = wb_valid_q;
    assign wb_reg_write    = wb_reg_write_q;
    assign wb_rd           = wb_rd_q;
    assign wb_data         = wb_data_q;
    assign mem_forward     = wb_data_q;
    assign misalign        = misalign_q;
    assign bus_error       = bus_error_q;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage; expected values are hand-computed constants.
module tb_mem_stage;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [31:0] in_write_data;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        in_mem_read;
    logic        in_mem_write;
    logic [1:0]  in_data_size;
    logic        in_data_sign;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] mem_forward;
    logic        misalign;
    logic        bus_error;

    int unsigned n_checks;
    int unsigned n_errors;

    mem_stage_if #(.WORD_SIZE(32)) dmem_bus ();

    mem_stage #(
        .WORD_SIZE(32),
        .NUM_REGS(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_result(in_result),
        .in_write_data(in_write_data),
        .in_rd(in_rd),
        .in_reg_write(in_reg_write),
        .in_mem_read(in_mem_read),
        .in_mem_write(in_mem_write),
        .in_data_size(in_data_size),
        .in_data_sign(in_data_sign),
        .dmem(dmem_bus),
        .wb_valid(wb_valid),
        .wb_reg_write(wb_reg_write),
        .wb_rd(wb_rd),
        .wb_data(wb_data),
        .mem_forward(mem_forward),
        .misalign(misalign),
        .bus_error(bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd_op, input logic wr_op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd, input logic rw,
                         input logic [1:0] size, input logic sgn);
        in_valid      = 1'b1;
        in_mem_read   = rd_op;
        in_mem_write  = wr_op;
        in_result     = addr;
        in_write_data = wd;
        in_rd         = rd;
        in_reg_write  = rw;
        in_data_size  = size;
        in_data_sign  = sgn;
    endtask

    task automatic idle_in();
        in_valid     = 1'b0;
        in_mem_read  = 1'b0;
        in_mem_write = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        idle_in();
        in_result = '0; in_write_data = '0; in_rd = '0; in_reg_write = 1'b0;
        in_data_size = '0; in_data_sign = 1'b0;
        dmem_bus.dmem_ack = 1'b0;
        dmem_bus.dmem_rdata = '0;
        step(); step();
        rst = 1'b0;
        check("rst_ready", in_ready, 1);
        check("rst_req", dmem_bus.dmem_req, 0);
        check("rst_wbv", wb_valid, 0);
        check("rst_wbdata", wb_data, 0);

        // ALU passthrough then two back-to-back ALU ops
        drive(0, 0, 32'd15, 0, 5'd3, 1, 2'b10, 0);
        step();
        drive(0, 0, 32'd7, 0, 5'd5, 1, 2'b10, 0);
        check("alu_wbv", wb_valid, 1);
        check("alu_data", wb_data, 15);
        check("alu_rd", wb_rd, 3);
        check("alu_rw", wb_reg_write, 1);
        check("alu_ready", in_ready, 1);
        check("alu_fwd", mem_forward, 15);
        step();
        drive(0, 0, 32'd9, 0, 5'd6, 0, 2'b10, 0);
        check("b2b1_data", wb_data, 7);
        check("b2b1_rd", wb_rd, 5);
        step();
        idle_in();
        check("b2b2_data", wb_data, 9);
        check("b2b2_rw", wb_reg_write, 0);
        step();
        check("alu_pulse", wb_valid, 0);
        check("alu_hold", wb_data, 9);

        // Signed byte load from lane 3, ack on 2nd BUSY cycle
        drive(1, 0, 32'h103, 0, 5'd7, 1, 2'b00, 1);
        step();
        idle_in();
        check("lb_ready0", in_ready, 0);
        check("lb_req", dmem_bus.dmem_req, 1);
        check("lb_we", dmem_bus.dmem_we, 0);
        check("lb_addr", dmem_bus.dmem_addr, 32'h100);
        check("lb_be", dmem_bus.dmem_be, 4'hF);
        step();
        check("lb_ready1", in_ready, 0);
        check("lb_req1", dmem_bus.dmem_req, 1);
        dmem_bus.dmem_ack = 1'b1;
        dmem_bus.dmem_rdata = 32'h80FF_1234;
        step();
        dmem_bus.dmem_ack = 1'b0;
        check("lb_wbv", wb_valid, 1);
        check("lb_data", wb_data, 32'hFFFF_FF80);
        check("lb_rw", wb_reg_write, 1);
        check("lb_rd", wb_rd, 7);
        check("lb_reqdrop", dmem_bus.dmem_req, 0);
        check("lb_ready", in_ready, 1);

        // Unsigned half load from lane 2, accepted in the same cycle as return to IDLE
        drive(1, 0, 32'h102, 0, 5'd8, 1, 2'b01, 0);
        step();
        idle_in();
        dmem_bus.dmem_ack = 1'b1;
        dmem_bus.dmem_rdata = 32'hBEEF_0000;
        step();
        dmem_bus.dmem_ack = 1'b0;
        check("lhu_data", wb_data, 32'h0000_BEEF);

        // Signed half load from lane 0
        drive(1, 0, 32'h100, 0, 5'd9, 1, 2'b01, 1);
        step();
        idle_in();
        dmem_bus.dmem_ack = 1'b1;
        dmem_bus.dmem_rdata = 32'h1234_8001;
        step();
        dmem_bus.dmem_ack = 1'b0;
        check("lh_data", wb_data, 32'hFFFF_8001);

        // Byte store lane 1
        drive(0, 1, 32'h201, 32'h0000_00AB, 5'd10, 1, 2'b00, 0);
        step();
        idle_in();
        check("sb_we", dmem_bus.dmem_we, 1);
        check("sb_addr", dmem_bus.dmem_addr, 32'h200);
        check("sb_be", dmem_bus.dmem_be, 4'b0010);
        check("sb_wdata", dmem_bus.dmem_wdata, 32'hABAB_ABAB);
        dmem_bus.dmem_ack = 1'b1;
        step();
        dmem_bus.dmem_ack = 1'b0;
        check("sb_wbv", wb_valid, 1);
        check("sb_rw", wb_reg_write, 0);

        // Half store lane 2
        drive(0, 1, 32'h202, 32'h1234_CDEF, 5'd11, 0, 2'b01, 0);
        step();
        idle_in();
        check("sh_be", dmem_bus.dmem_be, 4'b1100);
        check("sh_wdata", dmem_bus.dmem_wdata, 32'hCDEF_CDEF);
        dmem_bus.dmem_ack = 1'b1;
        step();
        dmem_bus.dmem_ack = 1'b0;

        // Misaligned word load and misaligned half store
        drive(1, 0, 32'h102, 0, 5'd12, 1, 2'b10, 0);
        step();
        idle_in();
        check("mw_req", dmem_bus.dmem_req, 0);
        check("mw_mis", misalign, 1);
        check("mw_wbv", wb_valid, 1);
        check("mw_rw", wb_reg_write, 0);
        check("mw_ready", in_ready, 1);
        step();
        check("mw_pulse", misalign, 0);
        drive(0, 1, 32'h101, 32'h55, 5'd0, 0, 2'b01, 0);
        step();
        idle_in();
        check("mh_mis", misalign, 1);
        check("mh_req", dmem_bus.dmem_req, 0);

        // Ack while IDLE is ignored
        dmem_bus.dmem_ack = 1'b1;
        step();
        dmem_bus.dmem_ack = 1'b0;
        check("idle_ack_wbv", wb_valid, 0);
        check("idle_ack_ready", in_ready, 1);

        // Timeout: 4 BUSY cycles without ack
        drive(1, 0, 32'h300, 0, 5'd13, 1, 2'b10, 0);
        step();
        idle_in();
        for (int i = 0; i < 4; i++) begin
            check("to_busy_req", dmem_bus.dmem_req, 1);
            check("to_busy_err", bus_error, 0);
            step();
        end
        check("to_err", bus_error, 1);
        check("to_wbv", wb_valid, 1);
        check("to_rw", wb_reg_write, 0);
        check("to_reqdrop", dmem_bus.dmem_req, 0);
        check("to_ready", in_ready, 1);
        step();
        check("to_pulse", bus_error, 0);

        // Ack on the final counted cycle wins over the timeout
        drive(1, 0, 32'h304, 0, 5'd14, 1, 2'b10, 0);
        step();
        idle_in();
        step(); step(); step();
        check("aw_req", dmem_bus.dmem_req, 1);
        dmem_bus.dmem_ack = 1'b1;
        dmem_bus.dmem_rdata = 32'h0000_0055;
        step();
        dmem_bus.dmem_ack = 1'b0;
        check("aw_err", bus_error, 0);
        check("aw_data", wb_data, 32'h55);
        check("aw_rw", wb_reg_write, 1);

        // Reset during BUSY
        drive(1, 0, 32'h400, 0, 5'd15, 1, 2'b10, 0);
        step();
        idle_in();
        check("rb_req", dmem_bus.dmem_req, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rb_ready", in_ready, 1);
        check("rb_req0", dmem_bus.dmem_req, 0);
        check("rb_addr", dmem_bus.dmem_addr, 0);
        check("rb_be", dmem_bus.dmem_be, 0);
        check("rb_wbdata", wb_data, 0);
        check("rb_wbrd", wb_rd, 0);
        check("rb_wbrw", wb_reg_write, 0);
        drive(0, 0, 32'h1234, 0, 5'd2, 1, 2'b10, 0);
        step();
        idle_in();
        check("rb_alu", wb_data, 32'h1234);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
